// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 program-memory controller.
//   - default address/data widths of the instruction store
//   - controller state encoding (2'd3 is unused and recovers to RUN)
//   - default power-up image of the instruction store
package td4_pkg;

    localparam int TD4_AW = 4;
    localparam int TD4_DW = 8;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } pm_state_e;

    // Entry i sits at bits [i*8 +: 8]; entry 0 is the rightmost byte.
    // Entry 3 is 8'hB5, every other entry i is 8'hE0 + i.
    localparam logic [16*8-1:0] TD4_DEFAULT_IMAGE =
        128'hEFEE_EDEC_EBEA_E9E8_E7E6_E5E4_B5E2_E1E0;

endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x DW instruction store.
//   clk    in   write clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  store[raddr], asynchronous read
// The store powers up holding INIT_IMAGE and has no reset, so a program
// survives any controller reset.
module prog_ram
    import td4_pkg::*;
#(
    parameter int                          AW         = TD4_AW,
    parameter int                          DW         = TD4_DW,
    parameter logic [(2**AW)*DW-1:0]       INIT_IMAGE = TD4_DEFAULT_IMAGE
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0][DW-1:0] mem = INIT_IMAGE;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Old contents are visible during the write cycle; the new byte
    // appears just after the edge that writes it.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: shares the TD4 instruction store between the CPU fetch
// port and a byte-serial program loader.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset (store is not cleared)
//   fetch_addr   in   CPU program counter
//   fetch_data   out  store[fetch_addr], combinational, any state
//   fetch_valid  out  high in RUN only
//   cpu_hold     out  high in LOAD and DONE
//   load_start   in   start/restart a load session
//   load_valid   in   loader byte present
//   load_data    in   loader byte
//   load_ready   out  high in LOAD
//   load_addr    out  current write pointer
//   load_done    out  one-cycle pulse after the last byte
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | CPU fetches and executes; loader ignored
// LOAD  | CPU held; one byte per handshake written at ptr, ptr++
// DONE  | single cycle after the last byte; pulses load_done
module prog_mem_ctrl
    import td4_pkg::*;
#(
    parameter int                          AW         = TD4_AW,
    parameter int                          DW         = TD4_DW,
    parameter logic [(2**AW)*DW-1:0]       INIT_IMAGE = TD4_DEFAULT_IMAGE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_data,
    output logic          fetch_valid,
    output logic          cpu_hold,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic [AW-1:0] load_addr,
    output logic          load_done
);

    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

    pm_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    we = 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
                // A restart overrides the pointer update (and completion)
                // but not the write of a coincident byte.
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                ptr_d   = '0;
            end
        endcase
    end

    // Control outputs decode from registered state only.
    assign fetch_valid = (state_q == ST_RUN);
    assign cpu_hold    = (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign load_ready  = (state_q == ST_LOAD);
    assign load_done   = (state_q == ST_DONE);
    assign load_addr   = ptr_q;

    prog_ram #(
        .AW         (AW),
        .DW         (DW),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_prog_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr_q),
        .wdata (load_data),
        .raddr (fetch_addr),
        .rdata (fetch_data)
    );

endmodule
